// File: rtl/mult_pkg.sv
// Shared definitions for the carry-save sequential multiplier: controller
// states and the product-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int W_DEFAULT = 8;
  localparam int PW        = 2 * W_DEFAULT;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of N independent full adders (3:2 compressor). The carry vector is
// returned unshifted; the caller aligns it to the next weight.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_mult_seq.sv
// Sequential unsigned W x W multiplier: one partial product per cycle into a
// carry-save accumulator, then a single resolving add into the product.
module csa_mult_seq
  import mult_pkg::*;
#(
  parameter int W          = W_DEFAULT,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*W-1:0]       product,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with its data until that edge.

  localparam int PWID = prod_width(W);
  localparam int CW   = $clog2(W + 1);

  state_t state, state_next;

  logic [W-1:0]    a_q, b_q;
  logic [PWID-1:0] s_q, c_q;
  logic [PWID-1:0] pp, row_sum, row_carry;
  logic [PWID-1:0] product_q;
  logic [CW-1:0]   cnt;
  logic            out_valid_q;
  logic [W-1:0]    b_shift, b_rest;
  logic            last_step;

  always_comb begin
    b_shift   = b_q >> cnt;
    b_rest    = b_q >> (cnt + 1'b1);
    pp        = b_shift[0] ? ({{W{1'b0}}, a_q} << cnt) : '0;
    // With early exit, stop once no set multiplier bits remain above cnt.
    last_step = (cnt == CW'(W - 1)) || (EARLY_EXIT && (b_rest == '0));
  end

  csa_row #(.N(PWID)) u_row (
    .x     (s_q),
    .y     (c_q),
    .z     (pp),
    .sum   (row_sum),
    .carry (row_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ACCUM;
      ACCUM:   if (last_step) state_next = RESOLVE;
      RESOLVE:                state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      c_q         <= '0;
      cnt         <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            s_q <= '0;
            c_q <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          s_q <= row_sum;
          // The carry leaving the top bit is always zero for W x W operands.
          c_q <= row_carry << 1;
          cnt <= cnt + 1'b1;
        end
        RESOLVE: begin
          product_q   <= s_q + c_q;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == ACCUM) || (state == RESOLVE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_csa_mult_seq.sv
// Directed and swept checks for csa_mult_seq, with one instance built without
// and one with early exit.
module tb_csa_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, b;
  logic        iv0, ir0, ov0, or0, busy0;
  logic        iv1, ir1, ov1, or1, busy1;
  logic [15:0] prod0, prod1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csa_mult_seq #(.W(8), .EARLY_EXIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(or0), .product(prod0), .busy(busy0)
  );

  csa_mult_seq #(.W(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(or1), .product(prod1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input bit ee, input logic [7:0] vb);
    int msb;
    if (!ee) return 9;
    msb = 0;
    for (int i = 0; i < 8; i++) if (vb[i]) msb = i;
    return msb + 2;
  endfunction

  function automatic logic [15:0] ref_mult(input logic [7:0] va, input logic [7:0] vb);
    logic [15:0] acc;
    acc = 16'h0;
    for (int i = 0; i < 8; i++) if (vb[i]) acc = acc + ({8'h00, va} << i);
    return acc;
  endfunction

  function automatic logic sel_ov(input bit ee);
    return ee ? ov1 : ov0;
  endfunction

  // Accept one operand pair, count edges until out_valid, check the result and
  // the handshake back to IDLE. out_ready of the chosen instance must be 1.
  task automatic do_mult(input bit ee, input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] exp_p, input string tag);
    int  lat;
    bit  ready_seen;
    @(negedge clk);
    a = va;
    b = vb;
    if (ee) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    lat = 0;
    ready_seen = 1'b0;
    while (!sel_ov(ee) && lat < 40) begin
      if (ee ? ir1 : ir0) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_latency(ee, vb));
    check({tag, " in_ready low"}, {31'b0, ready_seen}, 32'h0);
    check({tag, " product"}, {16'h0, (ee ? prod1 : prod0)}, {16'h0, exp_p});
    @(posedge clk);
    #1;
    check({tag, " out_valid drop"}, {31'b0, sel_ov(ee)}, 32'h0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    bit         ree;

    rst = 1'b1;
    a = 8'h00; b = 8'h00;
    iv0 = 1'b0; iv1 = 1'b0;
    or0 = 1'b1; or1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'b0, ov0}, 32'h0);
    check("reset product", {16'h0, prod0}, 32'h0);
    check("reset busy", {31'b0, busy0}, 32'h0);
    check("reset in_ready", {31'b0, ir0}, 32'h1);
    check("reset ee in_ready", {31'b0, ir1}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    do_mult(1'b0, 8'hFF, 8'hFF, 16'hFE01, "ff*ff");
    do_mult(1'b0, 8'h00, 8'hA5, 16'h0000, "00*a5");
    do_mult(1'b0, 8'h37, 8'h00, 16'h0000, "37*00");
    do_mult(1'b1, 8'h37, 8'h00, 16'h0000, "ee 37*00");
    do_mult(1'b1, 8'h00, 8'hA5, 16'h0000, "ee 00*a5");
    do_mult(1'b1, 8'h05, 8'h03, 16'h000F, "ee 05*03");
    do_mult(1'b0, 8'h80, 8'h80, 16'h4000, "80*80");
    do_mult(1'b0, 8'h01, 8'hFF, 16'h00FF, "01*ff");
    do_mult(1'b1, 8'h80, 8'h80, 16'h4000, "ee 80*80");

    // Back-pressure: hold out_ready low and pulse in_valid in DONE.
    @(negedge clk);
    or0 = 1'b0;
    a = 8'h0D; b = 8'h0B; iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("hold rise", {31'b0, ov0}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv0 = ~iv0;
      a = 8'h77; b = 8'h99;
      @(posedge clk);
      #1;
      check("hold out_valid", {31'b0, ov0}, 32'h1);
      check("hold product", {16'h0, prod0}, 32'h008F);
    end
    @(negedge clk);
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk);
    #1;
    check("hold release", {31'b0, ov0}, 32'h0);
    check("hold back idle", {31'b0, ir0}, 32'h1);
    @(posedge clk);
    #1;
    check("hold no stray accept", {31'b0, busy0}, 32'h0);

    // Reset in the middle of accumulation (cnt = 4).
    @(negedge clk);
    a = 8'h22; b = 8'hFF; iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre-reset busy", {31'b0, busy0}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst out_valid", {31'b0, ov0}, 32'h0);
    check("midrst product", {16'h0, prod0}, 32'h0);
    check("midrst busy", {31'b0, busy0}, 32'h0);
    check("midrst in_ready", {31'b0, ir0}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    do_mult(1'b0, 8'h12, 8'h34, 16'h03A8, "post-reset 12*34");

    for (int i = 0; i < 2000; i++) begin
      ra  = $urandom_range(0, 255);
      rb  = $urandom_range(0, 255);
      ree = $urandom_range(0, 1);
      do_mult(ree, ra, rb, ref_mult(ra, rb), "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
